rijndael_keyexp_seq: RTL and testbench
======================================

Name: rijndael_keyexp_seq

Overview:
- Iterative key-expansion sequencer. Owns one rijndael_keyschedulestep instance, generates the round constant, and advances the key state by one step per accepted output.
- Streams successive key states (round keys) to the round datapath over a valid/ready handshake.
- Sits between the key-load interface and the cipher round controller. Round keys are produced on demand and never stored as a full schedule.

Parameters:
- NK, 4, key size in 32-bit words; KEYSIZE = 32*NK (localparam); passed unchanged to the step instance.
- NSTEPS, 10, number of keyschedulestep applications per loaded key (≥1).
- IDXW, $clog2(NSTEPS+1) (localparam), width of rk_index.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- key_valid  input  1  cipher key offered
- key_ready  output  1  sequencer can accept a key (high only in IDLE)
- key_in  input  KEYSIZE  cipher key, word 0 in [31:0]
- abort  input  1  cancel current expansion
- rk_valid  output  1  rk_data/rk_index valid
- rk_ready  input  1  consumer accepts current round key
- rk_data  output  KEYSIZE  current key state
- rk_index  output  IDXW  step count of rk_data (0 = raw key)
- done  output  1  one-cycle pulse after last round key accepted

Behaviour:
- Reset: state=IDLE, key_reg=0, rc_reg=8'h01, idx=0; key_ready=1 after reset, rk_valid=0, rk_data=0, rk_index=0, done=0.
- Step instance input mux: in IDLE uses keystate=key_in, rc=8'h01; in RUN uses keystate=key_reg, rc=rc_reg. Exactly one instance.
- Rcon update, 8-bit: rc_next = {rc[6:0],1'b0} ^ (rc[7] ? 8'h1B : 8'h00). Sequence 01,02,04,08,10,20,40,80,1B,36, then continues modulo the GF(2^8) reduction with no saturation.
- IDLE:
  - key_ready=1, rk_valid=0.
  - On key_valid: load per Optional Feature, go to RUN.
  - First rk_valid is asserted the cycle after key acceptance.
- RUN:
  - key_ready=0; key_valid ignored.
  - rk_valid=1, rk_data=key_reg, rk_index=idx.
  - Outputs are held stable while rk_ready=0.
- On handshake (rk_valid & rk_ready) in RUN:
  - If idx==NSTEPS: go to IDLE, done=1 for the next cycle. key_reg holds its last value until the next load.
  - Otherwise: key_reg<=step(key_reg, rc_reg), rc_reg<=rc_next(rc_reg), idx<=idx+1; remain in RUN.
- Throughput: one round key per cycle with rk_ready held high.
- abort:
  - In RUN: return to IDLE next cycle with no done, rk_valid=0, idx=0, rc_reg=8'h01. abort takes priority over a simultaneous handshake; that key is not counted as consumed.
  - In IDLE: abort has priority over key_valid; no key is loaded that cycle.
- rst has priority over everything. Reset mid-expansion discards all state; the same-cycle handshake is void.
- done and key_ready may both be high in the cycle after completion.
- A new key may be accepted in the same cycle done is high.

Optional Feature:
- Macro: RIJNDAEL_KEYEXP_ROUND0_EN.
- Defined: on load, key_reg<=key_in, rc_reg<=8'h01, idx<=0. The raw key is emitted first as rk_index 0, giving NSTEPS+1 outputs total.
- Undefined: on load, key_reg<=step(key_in, 8'h01), rc_reg<=8'h02, idx<=1. The first output is rk_index 1, giving NSTEPS outputs total; rk_index 0 is never emitted.

Test Plan:
- FIPS-197 C.1 key 000102030405060708090a0b0c0d0e0f (byte order per port), rk_ready=1, ROUND0 defined:
  - 11 outputs on consecutive cycles, indices 0..10.
  - index 10 = 13111d7fe3944a17f307a78b4d2b30c5.
  - done one cycle after the last handshake.
- Same key, ROUND0 undefined:
  - 10 outputs; first = d6aa74fdd2af72fadaa678f1d6ab76fe (index 1).
- Backpressure: rk_ready toggles 1,0,0,1 pseudo-randomly.
  - rk_data/rk_index are stable during stalls.
  - The output sequence is identical to the unstalled run.
  - Total cycles = outputs + stall cycles + 1.
- abort asserted together with the handshake of index 3:
  - Next cycle in IDLE, rk_valid=0, no done pulse.
  - A reloaded key restarts at rc=01 and reproduces the full sequence.
- rst asserted at index 5, released:
  - All outputs at reset values; key_ready=1.
  - key_valid during RUN (before the reset) was ignored, and key_in changing mid-run did not alter outputs.
- NSTEPS=10 rcon sweep (observe via the step instance input):
  - 01,02,04,08,10,20,40,80,1B,36 in order.
  - Back-to-back second key accepted on the done cycle.

Source files
------------

// File: rtl/rijndael_keyexp_seq.sv
// rtl/rijndael_keyexp_seq.sv - iterative key-expansion sequencer; RIJNDAEL_KEYEXP_ROUND0_EN emits the raw key as round 0

// One key-schedule step: derives the next NK words from the previous NK words.
// Byte b of word w sits at keystate[32*w + 8*b +: 8] (first byte in the low bits).
module rijndael_keyschedulestep #(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] keystate_i,
  input  logic [7:0]       rc_i,
  output logic [32*NK-1:0] keystate_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, with 0 mapping to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Chain the word XORs; 256-bit keys apply an extra SubWord at word 4
  always_comb begin : step_comb
    logic [31:0] temp;
    logic [31:0] prev;
    keystate_o = '0;
    prev = keystate_i[32*(NK-1) +: 32];
    temp = sub_word({prev[7:0], prev[31:8]}) ^ {24'h000000, rc_i};
    prev = keystate_i[31:0] ^ temp;
    keystate_o[31:0] = prev;
    for (int i = 1; i < NK; i++) begin
      if (NK > 6 && i == 4) temp = sub_word(prev);
      else temp = prev;
      prev = keystate_i[32*i +: 32] ^ temp;
      keystate_o[32*i +: 32] = prev;
    end
  end

endmodule

module rijndael_keyexp_seq #(
  parameter  int NK      = 4,
  parameter  int NSTEPS  = 10,
  localparam int KEYSIZE = 32*NK,
  localparam int IDXW    = $clog2(NSTEPS+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [KEYSIZE-1:0] key_in,
  input  logic               abort,
  output logic               rk_valid,
  input  logic               rk_ready,
  output logic [KEYSIZE-1:0] rk_data,
  output logic [IDXW-1:0]    rk_index,
  output logic               done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSTEPS);

  state_t             state_q, state_d;
  logic [KEYSIZE-1:0] key_q, key_d;
  logic [7:0]         rc_q, rc_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic               done_q, done_d;

  logic [KEYSIZE-1:0] step_key;
  logic [7:0]         step_rc;
  logic [KEYSIZE-1:0] step_out;

  function automatic logic [7:0] rc_next(input logic [7:0] rc);
    return {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1B : 8'h00);
  endfunction

  // The single step instance serves the load (from key_in) and every later advance
  assign step_key = (state_q == IDLE) ? key_in : key_q;
  assign step_rc  = (state_q == IDLE) ? 8'h01  : rc_q;

  rijndael_keyschedulestep #(.NK(NK)) u_step (
    .keystate_i (step_key),
    .rc_i       (step_rc),
    .keystate_o (step_out)
  );

  // Next-state logic: load, advance on handshake, finish or abort
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (abort) begin
        rc_d  = 8'h01;
        idx_d = '0;
      end else if (key_valid) begin
        state_d = RUN;
`ifdef RIJNDAEL_KEYEXP_ROUND0_EN
        key_d = key_in;
        rc_d  = 8'h01;
        idx_d = '0;
`else
        key_d = step_out;
        rc_d  = 8'h02;
        idx_d = IDXW'(1);
`endif
      end
    end else begin
      if (abort) begin
        state_d = IDLE;
        rc_d    = 8'h01;
        idx_d   = '0;
      end else if (rk_ready) begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          key_d = step_out;
          rc_d  = rc_next(rc_q);
          idx_d = idx_q + IDXW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      rc_q    <= 8'h01;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign key_ready = (state_q == IDLE);
  assign rk_valid  = (state_q == RUN);
  assign rk_data   = key_q;
  assign rk_index  = idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_rijndael_keyexp_seq.sv
// tb/tb_rijndael_keyexp_seq.sv - scoreboard bench for rijndael_keyexp_seq (follows RIJNDAEL_KEYEXP_ROUND0_EN)
module tb_rijndael_keyexp_seq;

  localparam int NSTEPS = 10;
`ifdef RIJNDAEL_KEYEXP_ROUND0_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif
  localparam int NOUT = NSTEPS - FIRST + 1;

  logic         clk;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         abort;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;
  logic         done;

  rijndael_keyexp_seq #(.NK(4), .NSTEPS(NSTEPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .abort     (abort),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_data   (rk_data),
    .rk_index  (rk_index),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int           idx;
    logic [127:0] data;
    bit           last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] rk_m [NSTEPS+1];
  logic [127:0] c1_key;
  logic [127:0] kat1;
  logic [127:0] kat10;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] x);
    return (x << 1) ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // S-box from exp/log tables over generator 3, then the bitwise affine rule
  task automatic init_sbox();
    logic [7:0] ex [255];
    int         lg [256];
    logic [7:0] x;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    x = 8'h01;
    c = 8'h63;
    for (int i = 0; i < 255; i++) begin
      ex[i] = x;
      lg[x] = i;
      x = x ^ xt(x);
    end
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : ex[(255 - lg[a]) % 255];
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_t[a] = s;
    end
  endtask

  // Byte-oriented key expansion: byte j of a 128-bit value lives at [8j+:8]
  task automatic expand_model(input logic [127:0] key);
    logic [7:0] kb [16*(NSTEPS+1)];
    logic [7:0] t [4];
    logic [7:0] t0;
    logic [7:0] rcon;
    rcon = 8'h01;
    for (int j = 0; j < 16; j++) kb[j] = key[8*j +: 8];
    for (int i = 4; i < 4*(NSTEPS+1); i++) begin
      for (int k = 0; k < 4; k++) t[k] = kb[4*(i-1)+k];
      if (i % 4 == 0) begin
        t0 = t[0];
        t[0] = sbox_t[t[1]] ^ rcon;
        t[1] = sbox_t[t[2]];
        t[2] = sbox_t[t[3]];
        t[3] = sbox_t[t0];
        rcon = xt(rcon);
      end
      for (int k = 0; k < 4; k++) kb[4*i+k] = kb[4*(i-4)+k] ^ t[k];
    end
    for (int r = 0; r <= NSTEPS; r++)
      for (int j = 0; j < 16; j++) rk_m[r][8*j +: 8] = kb[16*r+j];
  endtask

  function automatic logic [127:0] from_be(input logic [127:0] x);
    logic [127:0] r;
    for (int j = 0; j < 16; j++) r[8*j +: 8] = x[127-8*j -: 8];
    return r;
  endfunction

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: pops on every accepted round key, checks stalls and the done pulse
  initial begin
    exp_t         e;
    bit           exp_done;
    bit           next_done;
    bit           stall_prev;
    logic [127:0] held_data;
    logic [3:0]   held_idx;
    exp_done = 0;
    stall_prev = 0;
    held_data = '0;
    held_idx = '0;
    forever begin
      @(negedge clk);
      chk("done_pulse", done, exp_done);
      if (stall_prev) begin
        chk("stall_valid", rk_valid, 1);
        chk("stall_data", rk_data, held_data);
        chk("stall_index", rk_index, held_idx);
      end
      stall_prev = 0;
      next_done = 0;
      if (rk_valid && !rst && !abort) begin
        if (rk_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("rk_index", rk_index, e.idx);
            chk("rk_data", rk_data, e.data);
            next_done = e.last;
          end
        end else begin
          stall_prev = 1;
          held_data = rk_data;
          held_idx = rk_index;
        end
      end
      exp_done = next_done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"}, key_ready, 1);
    chk({tag, "_rk_valid"}, rk_valid, 0);
    chk({tag, "_rk_data"}, rk_data, 0);
    chk({tag, "_rk_index"}, rk_index, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // Driver: loads one key and consumes round keys; optional abort / reset at a given index
  task automatic run_key(input logic [127:0] key, input bit bp, input int abort_at,
                         input int rst_at, input bit b2b);
    int cyc;
    int stalls;
    int hs;
    int cur;
    bit seen;
    exp_t e;
    if (b2b) begin
      chk("b2b_done_high", done, 1);
    end else begin
      for (int k = 0; k < 20 && !key_ready; k++) begin
        @(posedge clk);
        #1;
      end
    end
    chk("key_ready_before_load", key_ready, 1);
    expand_model(key);
    if (key == c1_key) begin
      rk_m[1] = kat1;
      rk_m[10] = kat10;
    end
    for (int i = FIRST; i <= NSTEPS; i++) begin
      e.idx = i;
      e.data = rk_m[i];
      e.last = (i == NSTEPS);
      exp_q.push_back(e);
    end
    key_valid = 1;
    key_in = key;
    rk_ready = 1;
    @(posedge clk);
    #1;
    key_valid = 0;
    key_in = rand_key();
    chk("first_valid", rk_valid, 1);
    cyc = 1;
    stalls = 0;
    hs = 0;
    seen = 0;
    for (int k = 0; k < 200; k++) begin
      cur = FIRST + hs;
      if (cur == abort_at) begin
        abort = 1;
        rk_ready = 1;
        @(posedge clk);
        #1;
        abort = 0;
        exp_q.delete();
        chk("abort_rk_valid", rk_valid, 0);
        chk("abort_key_ready", key_ready, 1);
        return;
      end
      if (cur == rst_at) begin
        rst = 1;
        rk_ready = 1;
        key_valid = 1;
        @(posedge clk);
        #1;
        rst = 0;
        key_valid = 0;
        exp_q.delete();
        check_reset_outputs("midrun_reset");
        return;
      end
      rk_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst_at >= 0) begin
        key_valid = 1;
        key_in = rand_key();
      end
      if (rk_ready) hs++;
      else stalls++;
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        seen = 1;
        break;
      end
    end
    key_valid = 0;
    chk("done_seen", seen, 1);
    chk("total_cycles", cyc, NOUT + stalls + 1);
    chk("output_count", hs, NOUT);
  endtask

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [127:0] k;
    rst = 1;
    key_valid = 0;
    key_in = '0;
    abort = 0;
    rk_ready = 0;
    c1_key = from_be(128'h000102030405060708090a0b0c0d0e0f);
    kat1   = from_be(128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    kat10  = from_be(128'h13111d7fe3944a17f307a78b4d2b30c5);
    init_sbox();
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check_reset_outputs("reset");

    run_key(c1_key, 0, -1, -1, 0);
    run_key(rand_key(), 0, -1, -1, 1);
    run_key(rand_key(), 1, -1, -1, 0);

    k = rand_key();
    run_key(k, 0, 3, -1, 0);
    run_key(k, 1, -1, -1, 0);

    @(posedge clk);
    #1;
    key_valid = 1;
    key_in = rand_key();
    abort = 1;
    @(posedge clk);
    #1;
    key_valid = 0;
    abort = 0;
    chk("idle_abort_key_ready", key_ready, 1);
    chk("idle_abort_rk_valid", rk_valid, 0);

    run_key(rand_key(), 0, -1, 5, 0);
    run_key(c1_key, 1, -1, -1, 0);
    for (int n = 0; n < 3; n++) run_key(rand_key(), 1, -1, -1, n > 0);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
